// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit and imem.
// The request side holds req/addr stable until ready is returned.
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_data);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_data);
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC sequencer with an IF/ID pipeline register.
// A one-entry skid buffer absorbs a fetch that completes while decode is stalled.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    pc_src,
    input  logic [31:0]             jump_address,
    input  logic                    stall,
    pc_fetch_unit_if.master         imem,
    output logic [31:0]             instr,
    output logic [31:0]             pc_plus_four,
    output logic                    instr_valid
);

    typedef enum logic {REQ, HOLD} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ifid_t;

    state_t      state;
    logic [31:0] pc;
    logic        pend;
    logic [31:0] pend_addr;
    ifid_t       skid;
    logic        take;
    logic [31:0] pc_next_seq;

    // Redirect only from a real instruction that decode is actually consuming.
    assign take        = pc_src & instr_valid & ~stall;
    assign pc_next_seq = pc + 32'd4;

    assign imem.imem_req  = (state == REQ) & ~reset;
    assign imem.imem_addr = pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc           <= RESET_PC;
            state        <= REQ;
            pend         <= 1'b0;
            pend_addr    <= 32'd0;
            skid         <= '0;
            instr        <= 32'd0;
            pc_plus_four <= 32'd0;
            instr_valid  <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (imem.imem_ready) begin
                        if (take || pend) begin
                            // Wrong-path word: drop it and refetch at the target.
                            pc   <= take ? jump_address : pend_addr;
                            pend <= 1'b0;
                            if (!stall) instr_valid <= 1'b0;
                        end else if (!stall) begin
                            instr        <= imem.imem_data;
                            pc_plus_four <= pc_next_seq;
                            instr_valid  <= 1'b1;
                            pc           <= pc_next_seq;
                        end else begin
                            skid  <= '{instr: imem.imem_data, pc4: pc_next_seq};
                            pc    <= pc_next_seq;
                            state <= HOLD;
                        end
                    end else begin
                        // Request is in flight and cannot be withdrawn; remember the target.
                        if (take) begin
                            pend      <= 1'b1;
                            pend_addr <= jump_address;
                        end
                        if (!stall) instr_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state <= REQ;
                        if (take) begin
                            instr_valid <= 1'b0;
                            pc          <= jump_address;
                        end else begin
                            instr        <= skid.instr;
                            pc_plus_four <= skid.pc4;
                            instr_valid  <= 1'b1;
                        end
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Fetch-stage PC sequencer and IF/ID pipeline register. Consumes the redirect produced in decode (`pc_src`, `jump_address`), owns the program counter, and issues instruction-memory requests over a ready-handshake. It presents the fetched instruction and its `pc_plus_four` to decode. The architecture has no branch delay slot: a redirect squashes every wrong-path fetch.

## Interface
Parameters:
- `RESET_PC`, default 32'h0040_0000: PC loaded on reset.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `pc_src` in 1: decode requests a redirect.
- `jump_address` in 32: redirect target; valid when `pc_src`=1.
- `stall` in 1: hazard unit freezes IF/ID; decode does not advance.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; always equals the PC register.
- `imem_ready` in 1: memory returns `imem_data` this cycle; ignored when `imem_req`=0.
- `imem_data` in 32: fetched word.
- `instr` out 32: IF/ID instruction.
- `pc_plus_four` out 32: IF/ID fetch address + 4.
- `instr_valid` out 1: IF/ID holds a real instruction (0 = bubble).

## Operation
- Redirect accept: `take` = `pc_src` & `instr_valid` & !`stall`. `pc_src` is ignored in any other cycle.
- Registers: `pc`, `state` {REQ, HOLD}, `pend` with `pend_addr`, skid buffer `buf_instr` and `buf_pc4`, and the IF/ID registers.
- `imem_req` = (`state`==REQ) & !`reset`. `imem_addr` = `pc`. Both stay stable until `imem_ready` arrives; an issued request is never withdrawn.
- REQ, `imem_ready`=1:
  - If `take` or `pend` is set: discard the data. Set `pc` to `jump_address` if `take`, otherwise to `pend_addr`. Clear `pend`. Stay in REQ. IF/ID: bubble if !`stall`.
  - Else if !`stall`: IF/ID <= {`imem_data`, `pc`+4, valid=1}. `pc` <= `pc`+4.
  - Else (`stall`=1): `buf` <= {`imem_data`, `pc`+4}. `pc` <= `pc`+4. Go to HOLD. IF/ID is held.
- REQ, `imem_ready`=0:
  - If `take`: `pend` <= 1 and `pend_addr` <= `jump_address`.
  - IF/ID: bubble (valid=0) if !`stall`; held if `stall`.
- HOLD (`imem_req`=0):
  - `stall`=1: everything is held.
  - `stall`=0 & `take`: drop `buf`, IF/ID becomes a bubble, `pc` <= `jump_address`, go to REQ.
  - `stall`=0 & !`take`: IF/ID <= {`buf`, valid=1}, go to REQ.
- A bubble clears only `instr_valid`. `instr` and `pc_plus_four` keep their previous values.
- PC arithmetic is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). Redirect targets are used unaligned as given.
- `pend` cannot be set twice. After `take`, IF/ID is a bubble, so no second `take` can occur before the in-flight fetch retires.

## Timing
- Reset values: `pc`=`RESET_PC`, `state`=REQ, `pend`=0, `instr`=0, `pc_plus_four`=0, `instr_valid`=0. `imem_req`=0 during any cycle where `reset`=1.
- The first request is issued in the cycle after `reset` falls.
- Zero-wait memory (`imem_ready` in the same cycle as `imem_req`): one instruction per cycle. `instr_valid` rises 1 cycle after the request.
- N wait cycles give N bubbles per instruction.
- Redirect penalty with zero-wait memory is exactly 1 bubble. The target request is issued in the cycle after `take`.
- Redirect during a wait: the old fetch completes and is discarded, then the target is fetched. The penalty is the remaining wait + 1 cycles.
- Stall release from HOLD: the buffered instruction appears in IF/ID 1 cycle later. The next request is issued in that same cycle.
- Reset asserted mid-request: the outstanding request is abandoned. The memory must tolerate a dropped request, and any `imem_ready` in the reset cycle is ignored.
- Simultaneous `take` and `imem_ready`: `jump_address` wins over `pend_addr`. `pend` is never set in that cycle.

## Test plan
- Reset release with `RESET_PC`=0x0040_0000, zero-wait memory returning addr^0xAAAA_AAAA:
  - Required: `imem_addr` sequence 0x400000, 0x400004, 0x400008.
  - Required: `instr_valid` goes 0,1,1,…; `pc_plus_four` is 0x400004, 0x400008, …
- `pc_src`=1 with `jump_address`=0x0040_0100, `instr_valid`=1, `stall`=0, zero-wait memory:
  - Required: next `imem_addr`=0x400100, exactly one bubble, the wrong-path word never reaches IF/ID.
- 3-wait-cycle memory, redirect to 0x500 accepted in the 1st wait cycle:
  - Required: `imem_addr` holds the old value until `imem_ready`, that data is discarded, next `imem_addr`=0x500.
- `stall`=1 for 4 cycles while a fetch returns 0x1234_5678:
  - Required: `imem_req`=0 during the remainder of the stall, and IF/ID is held.
  - Required: 1 cycle after release, `instr`=0x1234_5678 and `instr_valid`=1, with no fetch lost or duplicated.
- HOLD with a buffered word, then `stall`=0 together with `take` to 0x800:
  - Required: buffer dropped, `instr_valid`=0, next `imem_addr`=0x800.
- `pc`=0xFFFF_FFFC, zero-wait memory:
  - Required: next `imem_addr`=0x0000_0000 and `pc_plus_four`=0x0000_0000.
- `reset` asserted mid-wait:
  - Required: the next cycle has `imem_addr`=`RESET_PC` and `instr_valid`=0.
